argmax_pipe: RTL and testbench
==============================

# argmax_pipe

Parametrised, pipelined arg-max unit for the skin-classification datapath. Each accepted sample presents `N_CH` unsigned channel values; the block returns the largest value, the index of the channel holding it and, optionally, the margin over the runner-up. It replaces the fixed three-channel, single-register max stage. It sits between the per-channel score stage and the decision logic, under the same clock-enable stall scheme.

## Interface
- `N_CH`, default 3: number of channels, 1..16.
- `WIDTH`, default 10: bits per channel value, unsigned.
- `IDX_W`, localparam: `max(1, clog2(N_CH))`. Width of the index output.
- `LAT`, localparam: `max(1, clog2(N_CH))`. Pipeline latency in `ce`-qualified cycles.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `ce`, in, 1: clock enable. When low, the entire pipeline holds.
- `in_valid`, in, 1: the current `in_data` is a sample.
- `in_data`, in, `N_CH*WIDTH`: channel i is at `[i*WIDTH +: WIDTH]`.
- `out_valid`, out, 1: the outputs carry a result.
- `out_value`, out, `WIDTH`: maximum channel value.
- `out_index`, out, `IDX_W`: index of the winning channel.
- `out_margin`, out, `WIDTH`: `out_value` minus the second-largest value. Present only with `ARGMAX_MARGIN_EN`.

## Operation
- **Comparator tree.** The tree has `LAT` levels. Level k pairs adjacent entries of level k-1: 2j with 2j+1.
  - An odd leftover entry passes through that level unchanged, but it is still registered.
- **Entry contents.** Each entry carries {value, index, valid-tag}. With margin enabled it also carries second.
- **Merge rule.** `a.value >= b.value` selects a; otherwise b is selected. a is always the lower-index side.
  - Ties therefore resolve to the lowest channel index. Equal red/green/blue gives index 0.
- **Margin merge.** second = max(loser.value, winner.second).
  - Leaf entries start with second = 0.
  - `out_margin = out_value - second` is computed in the final stage. It is never negative.
- **Valid tracking.** `in_valid` travels alongside the tree in a `LAT`-deep valid pipe.
  - Data registers load every `ce` cycle, regardless of valid.
  - Outputs must be ignored when `out_valid`=0.
- **Stall.** `ce`=0 freezes all data and valid registers. `in_valid` is ignored while `ce`=0.
- **N_CH=1.** Single register stage. Index 0, value = input, margin = value.

## Timing
- A sample accepted at `ce`-edge t (with `ce`=1, `in_valid`=1) appears on the outputs after `LAT` `ce`-qualified rising edges.
  - Examples: `N_CH`=3 gives 2; `N_CH`=8 gives 3; `N_CH`=16 gives 4.
- Throughput is one sample per `ce` cycle, with no bubbles.
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Reset:** `rst` high clears every pipeline register asynchronously.
  - `out_valid`=0, `out_value`=0, `out_index`=0, `out_margin`=0.
  - Samples in flight are discarded.
  - After deassertion, the first valid output appears `LAT` `ce` cycles after the first accepted sample.
- **Stall and reset together:** `ce`=0 with `rst`=1 still resets.

## Configuration
- `ARGMAX_MARGIN_EN` defined:
  - The second-best value is tracked through the tree.
  - `out_margin` exists.
  - Latency is unchanged.
- `ARGMAX_MARGIN_EN` undefined:
  - The `out_margin` port and all second-value registers are absent.
  - Value and index behaviour is identical.

## Structure
- **Package `argmax_pkg`:**
  - `clog2` function.
  - `ARGMAX_MAX_CH` = 16.
  - Entry typedef `argmax_entry_t` (value, index, second) parametrised by `WIDTH`/`IDX_W` via the package defaults.
  - Shared merge function for the tie rule.
- **Sub-module `argmax_node`:** one registered two-input compare-merge cell with `ce`/`rst`. The tree is built from these with generate loops. Pass-through entries use the same register with b-side disabled.

## Test plan
- **Basic 3-channel:** `N_CH`=3, `WIDTH`=10, in = {r=512, g=100, b=1023}, `ce`=1 held → 2 cycles later: value 1023, index 2, margin 511, `out_valid`=1.
- **Ties:** in = {300, 300, 300} → index 0, margin 0. Then in = {5, 9, 9} → index 1, margin 0.
- **Stall:** two back-to-back samples, then `ce` low for 3 cycles mid-flight → outputs and `out_valid` frozen. Both results emerge in order once `ce` returns, with no loss or duplication.
- **Reset mid-operation:** 4 samples streaming, assert `rst` asynchronously between edges → all outputs read 0 immediately. After release, the first result appears exactly `LAT` cycles after the next sample.
- **8 channels, streaming:** `N_CH`=8, values {0, 7, 3, 1023, 1023, 2, 9, 8} → latency 3, value 1023, index 3, margin 0. Random streaming of 1000 samples is checked against a reference model.
- **Build variants:** build with `ARGMAX_MARGIN_EN` undefined → value/index match the enabled build cycle-for-cycle. `N_CH`=1 → latency 1, margin equals value.

Source files
------------

// File: rtl/argmax_pkg.sv
// Shared definitions for the arg-max pipeline: sizing helpers, entry type and the tie-break merge rule.
// The optional runner-up tracking is controlled by the ARGMAX_MARGIN_EN macro in the modules that import this.
package argmax_pkg;

    localparam int ARGMAX_MAX_CH = 16;
    localparam int ARGMAX_CMP_W  = 32;
    localparam int ARGMAX_WIDTH  = 10;
    localparam int ARGMAX_IDX_W  = 4;

    typedef struct packed {
        logic [ARGMAX_WIDTH-1:0] value;
        logic [ARGMAX_IDX_W-1:0] index;
        logic [ARGMAX_WIDTH-1:0] second;
    } argmax_entry_t;

    function automatic int clog2(input int n);
        int r;
        r = 32'sd0;
        while ((32'sd1 << r) < n) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Tree depth and index width: at least one register stage even for a single channel.
    function automatic int argmax_stages(input int n);
        return (clog2(n) < 32'sd1) ? 32'sd1 : clog2(n);
    endfunction

    function automatic int argmax_lvl_cnt(input int n, input int k);
        return (n + (32'sd1 << k) - 32'sd1) >> k;
    endfunction

    // The a side is always the lower-index side, so '>=' resolves ties to the lowest channel.
    function automatic logic argmax_pick_a(input logic [ARGMAX_CMP_W-1:0] a_value,
                                           input logic [ARGMAX_CMP_W-1:0] b_value);
        return (a_value >= b_value);
    endfunction

endpackage

// File: rtl/argmax_node.sv
// One registered compare-merge cell of the arg-max tree; HAS_B=0 makes it a registered pass-through.
// With ARGMAX_MARGIN_EN defined it also carries the runner-up value.
module argmax_node
    import argmax_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int IDX_W = 2,
    parameter bit HAS_B = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             a_valid_i,
    input  logic [WIDTH-1:0] a_value_i,
    input  logic [IDX_W-1:0] a_index_i,
    input  logic             b_valid_i,
    input  logic [WIDTH-1:0] b_value_i,
    input  logic [IDX_W-1:0] b_index_i,
`ifdef ARGMAX_MARGIN_EN
    input  logic [WIDTH-1:0] a_second_i,
    input  logic [WIDTH-1:0] b_second_i,
    output logic [WIDTH-1:0] second_o,
`endif
    output logic             valid_o,
    output logic [WIDTH-1:0] value_o,
    output logic [IDX_W-1:0] index_o
);

    logic             pick_a_s;
    logic             valid_d;
    logic [WIDTH-1:0] value_d;
    logic [IDX_W-1:0] index_d;
    logic             valid_q;
    logic [WIDTH-1:0] value_q;
    logic [IDX_W-1:0] index_q;

    // Select the winner of the pair.
    always_comb begin
        if (HAS_B) begin
            pick_a_s = argmax_pick_a(ARGMAX_CMP_W'(a_value_i), ARGMAX_CMP_W'(b_value_i));
            valid_d  = a_valid_i | b_valid_i;
        end else begin
            pick_a_s = 1'b1;
            valid_d  = a_valid_i;
        end
        if (pick_a_s) begin
            value_d = a_value_i;
            index_d = a_index_i;
        end else begin
            value_d = b_value_i;
            index_d = b_index_i;
        end
    end

    // Winner registers; ce low holds the stage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            value_q <= '0;
            index_q <= '0;
        end else if (ce_i) begin
            valid_q <= valid_d;
            value_q <= value_d;
            index_q <= index_d;
        end
    end

    assign valid_o = valid_q;
    assign value_o = value_q;
    assign index_o = index_q;

`ifdef ARGMAX_MARGIN_EN
    logic [WIDTH-1:0] loser_s;
    logic [WIDTH-1:0] win_second_s;
    logic [WIDTH-1:0] second_d;
    logic [WIDTH-1:0] second_q;

    // Runner-up is the larger of the losing value and what the winner already beat.
    always_comb begin
        if (!HAS_B) begin
            loser_s = '0;
        end else if (pick_a_s) begin
            loser_s = b_value_i;
        end else begin
            loser_s = a_value_i;
        end
        if (pick_a_s) begin
            win_second_s = a_second_i;
        end else begin
            win_second_s = b_second_i;
        end
        if (argmax_pick_a(ARGMAX_CMP_W'(loser_s), ARGMAX_CMP_W'(win_second_s))) begin
            second_d = loser_s;
        end else begin
            second_d = win_second_s;
        end
    end

    // Runner-up register, same enable and reset as the winner.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            second_q <= '0;
        end else if (ce_i) begin
            second_q <= second_d;
        end
    end

    assign second_o = second_q;
`endif

endmodule

// File: rtl/argmax_pipe.sv
// Pipelined arg-max over N_CH unsigned channels: one register level per tree level, LAT levels deep.
// Define ARGMAX_MARGIN_EN to add out_margin (winner minus runner-up).
module argmax_pipe
    import argmax_pkg::*;
#(
    parameter  int N_CH  = 3,
    parameter  int WIDTH = 10,
    localparam int IDX_W = argmax_stages(N_CH),
    localparam int LAT   = argmax_stages(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_value,
`ifdef ARGMAX_MARGIN_EN
    output logic [WIDTH-1:0]      out_margin,
`endif
    output logic [IDX_W-1:0]      out_index
);

    // Level 0 holds the unregistered leaves; levels 1..LAT are node registers.
    logic [WIDTH-1:0] val_s [LAT+1][N_CH];
    logic [IDX_W-1:0] idx_s [LAT+1][N_CH];
    logic             vld_s [LAT+1][N_CH];
`ifdef ARGMAX_MARGIN_EN
    logic [WIDTH-1:0] sec_s [LAT+1][N_CH];
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_leaf
        assign val_s[0][i] = in_data[i*WIDTH +: WIDTH];
        assign idx_s[0][i] = IDX_W'(i);
        assign vld_s[0][i] = in_valid;
`ifdef ARGMAX_MARGIN_EN
        assign sec_s[0][i] = '0;
`endif
    end

    for (genvar k = 1; k <= LAT; k++) begin : g_lvl
        localparam int PCNT = argmax_lvl_cnt(N_CH, k - 1);
        localparam int CNT  = argmax_lvl_cnt(N_CH, k);
        for (genvar j = 0; j < N_CH; j++) begin : g_slot
            if (j < CNT) begin : g_node
                // An odd leftover entry is fed to its own b port, which HAS_B=0 ignores.
                localparam bit HAS_B = ((2 * j + 1) < PCNT);
                localparam int BI    = HAS_B ? (2 * j + 1) : (2 * j);
                argmax_node #(
                    .WIDTH (WIDTH),
                    .IDX_W (IDX_W),
                    .HAS_B (HAS_B)
                ) u_node (
                    .clk_i      (clk),
                    .rst_i      (rst),
                    .ce_i       (ce),
                    .a_valid_i  (vld_s[k-1][2*j]),
                    .a_value_i  (val_s[k-1][2*j]),
                    .a_index_i  (idx_s[k-1][2*j]),
                    .b_valid_i  (vld_s[k-1][BI]),
                    .b_value_i  (val_s[k-1][BI]),
                    .b_index_i  (idx_s[k-1][BI]),
`ifdef ARGMAX_MARGIN_EN
                    .a_second_i (sec_s[k-1][2*j]),
                    .b_second_i (sec_s[k-1][BI]),
                    .second_o   (sec_s[k][j]),
`endif
                    .valid_o    (vld_s[k][j]),
                    .value_o    (val_s[k][j]),
                    .index_o    (idx_s[k][j])
                );
            end else begin : g_empty
                assign val_s[k][j] = '0;
                assign idx_s[k][j] = '0;
                assign vld_s[k][j] = 1'b0;
`ifdef ARGMAX_MARGIN_EN
                assign sec_s[k][j] = '0;
`endif
            end
        end
    end

    assign out_valid = vld_s[LAT][0];
    assign out_value = val_s[LAT][0];
    assign out_index = idx_s[LAT][0];
`ifdef ARGMAX_MARGIN_EN
    // Root second never exceeds root value, so the difference cannot wrap.
    assign out_margin = val_s[LAT][0] - sec_s[LAT][0];
`endif

endmodule

// File: tb/tb_argmax_pipe.sv
// Scoreboard bench for argmax_pipe with 3-, 8- and 1-channel instances sharing clk/rst/ce.
module tb_argmax_pipe;

    localparam int W    = 10;
    localparam int LAT3 = 2;
    localparam int LAT8 = 3;
    localparam int LAT1 = 1;

    typedef struct packed {
        int value;
        int index;
        int margin;
        int edge_n;
    } res_t;

    logic           clk;
    logic           rst;
    logic           ce;
    logic           v3, v8, v1;
    logic [3*W-1:0] d3;
    logic [8*W-1:0] d8;
    logic [W-1:0]   d1;
    logic           o3_valid, o8_valid, o1_valid;
    logic [W-1:0]   o3_value, o8_value, o1_value;
    logic [1:0]     o3_index;
    logic [2:0]     o8_index;
    logic [0:0]     o1_index;
`ifdef ARGMAX_MARGIN_EN
    logic [W-1:0]   o3_margin, o8_margin, o1_margin;
`endif

    int   checks = 0;
    int   errors = 0;
    int   ce_cnt = 0;
    res_t exp3[$], obs3[$], exp8[$], obs8[$], exp1[$], obs1[$];

    argmax_pipe #(.N_CH(3), .WIDTH(W)) u_dut3 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v3), .in_data(d3),
        .out_valid(o3_valid), .out_value(o3_value),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(o3_margin),
`endif
        .out_index(o3_index)
    );

    argmax_pipe #(.N_CH(8), .WIDTH(W)) u_dut8 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v8), .in_data(d8),
        .out_valid(o8_valid), .out_value(o8_value),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(o8_margin),
`endif
        .out_index(o8_index)
    );

    argmax_pipe #(.N_CH(1), .WIDTH(W)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(v1), .in_data(d1),
        .out_valid(o1_valid), .out_value(o1_value),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(o1_margin),
`endif
        .out_index(o1_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: linear scan, first strict maximum wins; runner-up is the max of all other channels.
    function automatic res_t ref_model(input int v[16], input int n, input int edge_n);
        res_t r;
        int   sec;
        r.value = v[0];
        r.index = 0;
        for (int i = 1; i < n; i++) begin
            if (v[i] > r.value) begin
                r.value = v[i];
                r.index = i;
            end
        end
        sec = 0;
        for (int i = 0; i < n; i++) begin
            if (i != r.index && v[i] > sec) sec = v[i];
        end
`ifdef ARGMAX_MARGIN_EN
        r.margin = r.value - sec;
`else
        r.margin = 0;
`endif
        r.edge_n = edge_n;
        return r;
    endfunction

    // One clock; record every result presented after a ce-qualified edge.
    task automatic tick();
        bit   q;
        res_t r;
        int   m3, m8, m1;
        @(posedge clk);
        q = ce && !rst;
        if (q) ce_cnt++;
        #1;
`ifdef ARGMAX_MARGIN_EN
        m3 = int'(o3_margin); m8 = int'(o8_margin); m1 = int'(o1_margin);
`else
        m3 = 0; m8 = 0; m1 = 0;
`endif
        if (q && o3_valid) begin
            r = '{value: int'(o3_value), index: int'(o3_index), margin: m3, edge_n: ce_cnt};
            obs3.push_back(r);
        end
        if (q && o8_valid) begin
            r = '{value: int'(o8_value), index: int'(o8_index), margin: m8, edge_n: ce_cnt};
            obs8.push_back(r);
        end
        if (q && o1_valid) begin
            r = '{value: int'(o1_value), index: int'(o1_index), margin: m1, edge_n: ce_cnt};
            obs1.push_back(r);
        end
    endtask

    task automatic idle(input int n);
        v3 = 1'b0; v8 = 1'b0; v1 = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send3(input int r, input int g, input int b);
        int v[16];
        v = '{default: 0};
        v[0] = r; v[1] = g; v[2] = b;
        d3 = {W'(b), W'(g), W'(r)};
        v3 = 1'b1;
        if (ce && !rst) exp3.push_back(ref_model(v, 3, ce_cnt + LAT3));
        tick();
    endtask

    task automatic send8(input int v[16], input bit valid);
        for (int i = 0; i < 8; i++) d8[i*W +: W] = W'(v[i]);
        v8 = valid;
        if (valid && ce && !rst) exp8.push_back(ref_model(v, 8, ce_cnt + LAT8));
        tick();
    endtask

    task automatic send1(input int x);
        int v[16];
        v = '{default: 0};
        v[0] = x;
        d1 = W'(x);
        v1 = 1'b1;
        if (ce && !rst) exp1.push_back(ref_model(v, 1, ce_cnt + LAT1));
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1;
        v3 = 1'b1; v8 = 1'b1; v1 = 1'b1;
        d3 = '1; d8 = '1; d1 = '1;
        tick(); tick();
        checks++;
        if ({o3_valid, o3_value, o3_index} !== '0) begin
            errors++; $display("FAIL reset3 got v=%b val=%0d idx=%0d want 0 0 0", o3_valid, o3_value, o3_index);
        end
        checks++;
        if ({o8_valid, o8_value, o8_index} !== '0) begin
            errors++; $display("FAIL reset8 got v=%b val=%0d idx=%0d want 0 0 0", o8_valid, o8_value, o8_index);
        end
        checks++;
        if ({o1_valid, o1_value, o1_index} !== '0) begin
            errors++; $display("FAIL reset1 got v=%b val=%0d idx=%0d want 0 0 0", o1_valid, o1_value, o1_index);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if ({o3_margin, o8_margin, o1_margin} !== '0) begin
            errors++; $display("FAIL reset_margin got %0d %0d %0d want 0 0 0", o3_margin, o8_margin, o1_margin);
        end
`endif
        rst = 1'b0;
        idle(2);
        exp3.delete(); obs3.delete(); exp8.delete(); obs8.delete(); exp1.delete(); obs1.delete();
    endtask

    task automatic test_basic_ties();
        res_t e, o;
        send3(512, 100, 1023);
        send3(300, 300, 300);
        send3(5, 9, 9);
        send3(0, 0, 1);
        idle(4);
        while (exp3.size() != 0) begin
            e = exp3.pop_front(); checks++;
            if (obs3.size() == 0) begin
                errors++; $display("FAIL basic3 got no result want v=%0d i=%0d", e.value, e.index);
            end else begin
                o = obs3.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL basic3 got v=%0d i=%0d m=%0d t=%0d want v=%0d i=%0d m=%0d t=%0d",
                                       o.value, o.index, o.margin, o.edge_n, e.value, e.index, e.margin, e.edge_n);
                end
            end
        end
        checks++;
        if (obs3.size() != 0) begin
            errors++; $display("FAIL basic3_extra got %0d results want 0", obs3.size()); obs3.delete();
        end
    endtask

    task automatic test_stall();
        res_t       e, o;
        logic [12:0] snap;
        send3(10, 20, 30);
        send3(40, 5, 40);
        snap = {o3_valid, o3_value, o3_index};
        ce = 1'b0; v3 = 1'b1; d3 = {10'd1023, 10'd1023, 10'd1023};
        repeat (3) begin
            tick();
            checks++;
            if ({o3_valid, o3_value, o3_index} !== snap) begin
                errors++; $display("FAIL stall_hold got %h want %h", {o3_valid, o3_value, o3_index}, snap);
            end
        end
        ce = 1'b1;
        idle(4);
        while (exp3.size() != 0) begin
            e = exp3.pop_front(); checks++;
            if (obs3.size() == 0) begin
                errors++; $display("FAIL stall got no result want v=%0d i=%0d", e.value, e.index);
            end else begin
                o = obs3.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL stall got v=%0d i=%0d m=%0d t=%0d want v=%0d i=%0d m=%0d t=%0d",
                                       o.value, o.index, o.margin, o.edge_n, e.value, e.index, e.margin, e.edge_n);
                end
            end
        end
        checks++;
        if (obs3.size() != 0) begin
            errors++; $display("FAIL stall_extra got %0d results want 0", obs3.size()); obs3.delete();
        end
    endtask

    task automatic test_reset_mid();
        res_t e, o;
        for (int s = 0; s < 4; s++) begin
            send3(600 + s, 900 - s, 3 * s);
        end
        #2;
        ce = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if ({o3_valid, o3_value, o3_index} !== '0) begin
            errors++; $display("FAIL reset_mid got v=%b val=%0d idx=%0d want 0 0 0", o3_valid, o3_value, o3_index);
        end
`ifdef ARGMAX_MARGIN_EN
        checks++;
        if (o3_margin !== '0) begin
            errors++; $display("FAIL reset_mid_margin got %0d want 0", o3_margin);
        end
`endif
        exp3.delete(); obs3.delete();
        idle(1);
        rst = 1'b0; ce = 1'b1;
        idle(3);
        send3(7, 700, 70);
        idle(4);
        while (exp3.size() != 0) begin
            e = exp3.pop_front(); checks++;
            if (obs3.size() == 0) begin
                errors++; $display("FAIL after_reset got no result want v=%0d i=%0d", e.value, e.index);
            end else begin
                o = obs3.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL after_reset got v=%0d i=%0d m=%0d t=%0d want v=%0d i=%0d m=%0d t=%0d",
                                       o.value, o.index, o.margin, o.edge_n, e.value, e.index, e.margin, e.edge_n);
                end
            end
        end
        checks++;
        if (obs3.size() != 0) begin
            errors++; $display("FAIL after_reset_extra got %0d results want 0", obs3.size()); obs3.delete();
        end
    endtask

    task automatic test_ch8_stream();
        res_t e, o;
        int   v[16];
        v = '{default: 0};
        v[0] = 0; v[1] = 7; v[2] = 3; v[3] = 1023; v[4] = 1023; v[5] = 2; v[6] = 9; v[7] = 8;
        send8(v, 1'b1);
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 8; i++) begin
                v[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1023));
            end
            ce = ($urandom_range(0, 9) != 0);
            send8(v, $urandom_range(0, 3) != 0);
        end
        ce = 1'b1;
        idle(5);
        while (exp8.size() != 0) begin
            e = exp8.pop_front(); checks++;
            if (obs8.size() == 0) begin
                errors++; $display("FAIL ch8 got no result want v=%0d i=%0d", e.value, e.index);
            end else begin
                o = obs8.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL ch8 got v=%0d i=%0d m=%0d t=%0d want v=%0d i=%0d m=%0d t=%0d",
                                       o.value, o.index, o.margin, o.edge_n, e.value, e.index, e.margin, e.edge_n);
                end
            end
        end
        checks++;
        if (obs8.size() != 0) begin
            errors++; $display("FAIL ch8_extra got %0d results want 0", obs8.size()); obs8.delete();
        end
    endtask

    task automatic test_ch1();
        res_t e, o;
        send1(0);
        send1(1023);
        send1(517);
        idle(3);
        while (exp1.size() != 0) begin
            e = exp1.pop_front(); checks++;
            if (obs1.size() == 0) begin
                errors++; $display("FAIL ch1 got no result want v=%0d", e.value);
            end else begin
                o = obs1.pop_front();
                if (o !== e) begin
                    errors++; $display("FAIL ch1 got v=%0d i=%0d m=%0d t=%0d want v=%0d i=%0d m=%0d t=%0d",
                                       o.value, o.index, o.margin, o.edge_n, e.value, e.index, e.margin, e.edge_n);
                end
            end
        end
        checks++;
        if (obs1.size() != 0) begin
            errors++; $display("FAIL ch1_extra got %0d results want 0", obs1.size()); obs1.delete();
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1;
        v3 = 1'b0; v8 = 1'b0; v1 = 1'b0;
        d3 = '0; d8 = '0; d1 = '0;
        test_reset();
        test_basic_ties();
        test_stall();
        test_reset_mid();
        test_ch8_stream();
        test_ch1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
